hbridge_dir_driver: RTL and testbench
=====================================

Name: hbridge_dir_driver

Overview:
- Consumer end of the direction-command interface: takes the periodic dirL/dirR toggles from the direction generator and drives the two H-bridge channels.
- Each direction change runs a safe reversal: brake, then dead-time coast, then a PWM duty ramp back up.
- Sits between the direction/timing logic and the motor driver pins of the line-follow robot.

Parameters:
- PWM_BITS, 8, width of the duty command and the PWM counter.
- DEAD_TICKS, 50000, clk cycles spent in each of BRAKE and DEAD (1 ms at 50 MHz).
- RAMP_STEP_TICKS, 50000, clk cycles between +1 duty steps while ramping.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  1 = motors enabled; 0 = coast.
- dirL  in  1  left direction command; 1 = forward.
- dirR  in  1  right direction command; 1 = forward.
- duty  in  PWM_BITS  target duty, shared by both channels.
- mL_a  out  1  left bridge input A.
- mL_b  out  1  left bridge input B.
- mR_a  out  1  right bridge input A.
- mR_b  out  1  right bridge input B.
- busyL  out  1  left channel is in BRAKE or DEAD.
- busyR  out  1  right channel is in BRAKE or DEAD.

Behaviour:
- Input capture: dirL, dirR, en and duty are registered once on posedge, because the source launches on negedge. This adds 1 cycle of input latency.
- Reset (rst=0, async):
  - all outputs 0, busy 0, both channels in STOP;
  - cur_duty 0, active_dir 1, timers 0, PWM counter 0.
- PWM counter:
  - free-running 0..2^PWM_BITS-2, then wraps to 0; shared by both channels;
  - pwm_on = (cnt < cur_duty);
  - duty 0 gives a constant-low output; duty all-ones gives a constant-high output.
- Drive rules:
  - RAMP/RUN: if active_dir=1 then a=pwm_on, b=0; else a=0, b=pwm_on.
  - STOP/DEAD: a=b=0 (coast).
  - BRAKE: a=b=1.
  - a=b=1 occurs in no other state.
- Per-channel FSM (STOP, RAMP, RUN, BRAKE, DEAD):
  - STOP: cur_duty=0. When en_q=1, latch active_dir=dir_q, clear the step timer, go to RAMP.
  - RAMP: each RAMP_STEP_TICKS cycles, cur_duty += 1. When cur_duty == duty_q, go to RUN. If duty_q < cur_duty, load cur_duty=duty_q and go to RUN on the same cycle.
  - RUN: a lower duty_q is applied immediately. A higher duty_q sends the channel back to RAMP, with no jump.
  - RAMP/RUN with dir_q != active_dir: go to BRAKE. Set cur_duty=0 and load the timer with DEAD_TICKS-1.
  - BRAKE: when the timer reaches 0, go to DEAD and reload the timer.
  - DEAD: when the timer reaches 0, latch active_dir=dir_q and go to RAMP from 0.
  - If the direction toggles again during BRAKE/DEAD, the sequence still completes. The final direction is sampled only at the DEAD exit. If dir_q then equals the old active_dir, the channel ramps in the old direction.
- en_q=0 in any state: the next state is STOP, which aborts BRAKE/DEAD, and busy drops.
- Simultaneous en_q=0 and a direction change: en has priority, and the channel goes to STOP.
- busyX = 1 exactly while that channel is in BRAKE or DEAD.
- The two channels are independent: dirL and dirR changing on the same cycle start both sequences in lockstep.
- Timers are sized by $clog2 of the maximum of DEAD_TICKS and RAMP_STEP_TICKS. They are down-counters and saturate at 0.
- cur_duty never exceeds duty_q and never wraps.

Decomposition:
- Shared package holds:
  - the channel state enum (STOP, RAMP, RUN, BRAKE, DEAD);
  - the drive-code constants COAST=2'b00, BRAKE=2'b11.
- Natural sub-module: hbridge_channel.
  - One FSM, duty ramp and timer per motor, instantiated twice.
  - Inputs: clk, rst, en_q, dir_q, duty_q, pwm cnt.
  - Outputs: a, b, busy.
- The top level holds the input registers and the shared PWM counter.

Test Plan (PWM_BITS=4, DEAD_TICKS=4, RAMP_STEP_TICKS=2):
1. Reset, then en=1, dirL=dirR=1, duty=6 -> cur_duty reaches 6 after 12 step cycles. mL_a is high for 6 of every 15 cycles, and mL_b=0 throughout.
2. In RUN, toggle dirL to 0 -> 2 cycles later mL_a=mL_b=1 for 4 cycles, then 0/0 for 4 cycles, with busyL=1 for those 8 cycles. mL_b then ramps from duty 0, while the right channel is unaffected.
3. Toggle dirL 0 then back to 1 within BRAKE -> the full 8-cycle sequence completes, then the channel ramps with mL_a active.
4. Drop en during DEAD -> the next cycle after capture shows all outputs 0, busy=0, STOP. Raising en restarts the ramp from 0.
5. duty=15 in RUN, then duty=3 -> high-time becomes 3/15 from the next PWM period. Then duty=15 with duty all-ones -> ramp resumes at +1 per 2 cycles, ending in constant-high output.
6. Assert rst mid-BRAKE, asynchronously between clock edges -> outputs go to 0 immediately without waiting for an edge. After release, STOP holds with en=0.

Source files
------------

// File: rtl/hbridge_dir_driver_pkg.sv
// rtl/hbridge_dir_driver_pkg.sv - shared channel state and bridge drive codes
// Contents: ch_state_t (per-channel FSM states), DRV_COAST / DRV_BRAKE ({a,b} drive codes).
package hbridge_dir_driver_pkg;

  typedef enum logic [2:0] {
    ST_STOP,
    ST_RAMP,
    ST_RUN,
    ST_BRAKE,
    ST_DEAD
  } ch_state_t;

  localparam logic [1:0] DRV_COAST = 2'b00;
  localparam logic [1:0] DRV_BRAKE = 2'b11;

endpackage

// File: rtl/hbridge_dir_driver_if.sv
// rtl/hbridge_dir_driver_if.sv - direction-command in, H-bridge pins out
// Signals: en, dirL, dirR, duty (command side); mL_a/mL_b, mR_a/mR_b, busyL/busyR (bridge side).
// Modports: master = command source / pin observer, slave = the driver.
interface hbridge_dir_driver_if #(
  parameter int PWM_BITS = 8
);
  logic                en;
  logic                dirL;
  logic                dirR;
  logic [PWM_BITS-1:0] duty;
  logic                mL_a;
  logic                mL_b;
  logic                mR_a;
  logic                mR_b;
  logic                busyL;
  logic                busyR;

  modport master (
    output en, dirL, dirR, duty,
    input  mL_a, mL_b, mR_a, mR_b, busyL, busyR
  );

  modport slave (
    input  en, dirL, dirR, duty,
    output mL_a, mL_b, mR_a, mR_b, busyL, busyR
  );
endinterface

// File: rtl/hbridge_dir_driver_channel.sv
// rtl/hbridge_dir_driver_channel.sv - one H-bridge channel: reversal FSM, duty ramp, timer
// Ports: clk, rst (async, active low); en_q, dir_q, duty_q (registered commands);
//        cnt_nxt (value the shared PWM counter takes on this edge); a, b, busy (registered).
module hbridge_channel
  import hbridge_dir_driver_pkg::*;
#(
  parameter int PWM_BITS        = 8,
  parameter int DEAD_TICKS      = 50000,
  parameter int RAMP_STEP_TICKS = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_q,
  input  logic                dir_q,
  input  logic [PWM_BITS-1:0] duty_q,
  input  logic [PWM_BITS-1:0] cnt_nxt,
  output logic                a,
  output logic                b,
  output logic                busy
);

  localparam int MAX_TICKS = (DEAD_TICKS > RAMP_STEP_TICKS) ? DEAD_TICKS : RAMP_STEP_TICKS;
  localparam int TW        = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS);
  localparam logic [TW-1:0] DEAD_LOAD = TW'(DEAD_TICKS - 1);
  localparam logic [TW-1:0] STEP_LOAD = TW'(RAMP_STEP_TICKS - 1);

  ch_state_t           state, state_nxt;
  logic [PWM_BITS-1:0] cur_duty, duty_nxt;
  logic                active_dir, dir_nxt;
  logic [TW-1:0]       timer, timer_nxt;
  logic                pwm_nxt;
  logic [1:0]          drv_nxt;

  always_comb begin
    state_nxt = state;
    duty_nxt  = cur_duty;
    dir_nxt   = active_dir;
    timer_nxt = timer;
    if (!en_q) begin
      // Disable wins over everything, including a pending reversal.
      state_nxt = ST_STOP;
      duty_nxt  = '0;
      timer_nxt = '0;
    end else begin
      case (state)
        ST_STOP: begin
          dir_nxt   = dir_q;
          duty_nxt  = '0;
          timer_nxt = STEP_LOAD;
          state_nxt = ST_RAMP;
        end
        ST_RAMP, ST_RUN: begin
          if (dir_q != active_dir) begin
            state_nxt = ST_BRAKE;
            duty_nxt  = '0;
            timer_nxt = DEAD_LOAD;
          end else if (duty_q <= cur_duty) begin
            // Reaching or dropping below target settles in RUN at once.
            duty_nxt  = duty_q;
            state_nxt = ST_RUN;
          end else if (state == ST_RUN) begin
            state_nxt = ST_RAMP;
            timer_nxt = STEP_LOAD;
          end else if (timer == '0) begin
            duty_nxt  = cur_duty + 1'b1;
            timer_nxt = STEP_LOAD;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        ST_BRAKE: begin
          if (timer == '0) begin
            state_nxt = ST_DEAD;
            timer_nxt = DEAD_LOAD;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        ST_DEAD: begin
          // Direction is re-sampled only here; toggles during BRAKE/DEAD are ignored.
          if (timer == '0) begin
            dir_nxt   = dir_q;
            duty_nxt  = '0;
            timer_nxt = STEP_LOAD;
            state_nxt = ST_RAMP;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
        default: state_nxt = ST_STOP;
      endcase
    end
  end

  // Outputs are registered from next-state values so pins line up with the state register.
  always_comb begin
    pwm_nxt = (cnt_nxt < duty_nxt);
    drv_nxt = DRV_COAST;
    case (state_nxt)
      ST_RAMP, ST_RUN: drv_nxt = dir_nxt ? {pwm_nxt, 1'b0} : {1'b0, pwm_nxt};
      ST_BRAKE:        drv_nxt = DRV_BRAKE;
      default:         drv_nxt = DRV_COAST;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_STOP;
      cur_duty   <= '0;
      active_dir <= 1'b1;
      timer      <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_duty   <= duty_nxt;
      active_dir <= dir_nxt;
      timer      <= timer_nxt;
      {a, b}     <= drv_nxt;
      busy       <= (state_nxt == ST_BRAKE) || (state_nxt == ST_DEAD);
    end
  end

endmodule

// File: rtl/hbridge_dir_driver.sv
// rtl/hbridge_dir_driver.sv - dual H-bridge direction driver with safe reversal
// Ports: clk, rst (async, active low); bus (slave): en, dirL, dirR, duty in;
//        mL_a, mL_b, mR_a, mR_b, busyL, busyR out.
module hbridge_dir_driver
  import hbridge_dir_driver_pkg::*;
#(
  parameter int PWM_BITS        = 8,
  parameter int DEAD_TICKS      = 50000,
  parameter int RAMP_STEP_TICKS = 50000
) (
  input logic               clk,
  input logic               rst,
  hbridge_dir_driver_if.slave bus
);

  // Period is 2^N-1 so that an all-ones duty gives a constant-high output.
  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic                en_q;
  logic                dir_l_q;
  logic                dir_r_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] cnt_nxt;

  assign cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

  // Commands are launched on negedge upstream; one posedge register gives a clean sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= 1'b0;
      dir_l_q <= 1'b0;
      dir_r_q <= 1'b0;
      duty_q  <= '0;
      cnt     <= '0;
    end else begin
      en_q    <= bus.en;
      dir_l_q <= bus.dirL;
      dir_r_q <= bus.dirR;
      duty_q  <= bus.duty;
      cnt     <= cnt_nxt;
    end
  end

  hbridge_channel #(
    .PWM_BITS       (PWM_BITS),
    .DEAD_TICKS     (DEAD_TICKS),
    .RAMP_STEP_TICKS(RAMP_STEP_TICKS)
  ) u_left (
    .clk    (clk),
    .rst    (rst),
    .en_q   (en_q),
    .dir_q  (dir_l_q),
    .duty_q (duty_q),
    .cnt_nxt(cnt_nxt),
    .a      (bus.mL_a),
    .b      (bus.mL_b),
    .busy   (bus.busyL)
  );

  hbridge_channel #(
    .PWM_BITS       (PWM_BITS),
    .DEAD_TICKS     (DEAD_TICKS),
    .RAMP_STEP_TICKS(RAMP_STEP_TICKS)
  ) u_right (
    .clk    (clk),
    .rst    (rst),
    .en_q   (en_q),
    .dir_q  (dir_r_q),
    .duty_q (duty_q),
    .cnt_nxt(cnt_nxt),
    .a      (bus.mR_a),
    .b      (bus.mR_b),
    .busy   (bus.busyR)
  );

endmodule

// File: tb/tb_hbridge_dir_driver.sv
// tb/tb_hbridge_dir_driver.sv - directed bench for hbridge_dir_driver
module tb_hbridge_dir_driver;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hbridge_dir_driver_if #(.PWM_BITS(PW)) bus();

  hbridge_dir_driver #(
    .PWM_BITS       (PW),
    .DEAD_TICKS     (4),
    .RAMP_STEP_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic          en;
    logic          dl;
    logic          dr;
    logic [PW-1:0] duty;
    int            settle;
    int            la, lb, ra, rb;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic dl, input logic dr, input logic [PW-1:0] duty);
    bus.en   = en;
    bus.dirL = dl;
    bus.dirR = dr;
    bus.duty = duty;
  endtask

  function automatic logic [5:0] outs();
    return {bus.mL_a, bus.mL_b, bus.mR_a, bus.mR_b, bus.busyL, bus.busyR};
  endfunction

  // High-time of each pin over one full 15-cycle PWM period, plus busy at the end.
  task automatic window(input string tag, input int la, input int lb, input int ra, input int rb);
    int cla, clb, cra, crb;
    cla = 0; clb = 0; cra = 0; crb = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      cla += int'(bus.mL_a);
      clb += int'(bus.mL_b);
      cra += int'(bus.mR_a);
      crb += int'(bus.mR_b);
    end
    check({tag, " mL_a high"}, cla, la);
    check({tag, " mL_b high"}, clb, lb);
    check({tag, " mR_a high"}, cra, ra);
    check({tag, " mR_b high"}, crb, rb);
    check({tag, " busy"}, int'({bus.busyL, bus.busyR}), 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 4'd6,  20,  6,  0,  6,  0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 4'd3,   3,  3,  0,  3,  0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 4'd15, 30, 15,  0, 15,  0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 4'd15, 50,  0, 15, 15,  0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 4'd15,  3,  0,  0,  0,  0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 4'd0,   5,  0,  0,  0,  0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 4'd1,   8,  1,  0,  0,  1};

    drive(1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    check("reset outputs", int'(outs()), 0);
    rst = 1'b1;
    tick();
    tick();
    check("idle after reset", int'(outs()), 0);

    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].en, vecs[v].dl, vecs[v].dr, vecs[v].duty);
      for (int i = 0; i < vecs[v].settle; i++) tick();
      window($sformatf("vec%0d", v), vecs[v].la, vecs[v].lb, vecs[v].ra, vecs[v].rb);
    end

    // Reversal timing: 4 cycles brake, 4 cycles coast, right channel untouched.
    drive(1'b1, 1'b1, 1'b1, 4'd6);
    for (int i = 0; i < 40; i++) tick();
    bus.dirL = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 2) begin
        check($sformatf("rev k%0d {a,b,busy}", k), int'({bus.mL_a, bus.mL_b, bus.busyL}),
              (k <= 5) ? 7 : (k <= 9) ? 1 : 0);
      end
      check($sformatf("rev k%0d busyR", k), int'(bus.busyR), 0);
    end

    // Toggle back during BRAKE: sequence still runs its full length, ends forward.
    bus.dirL = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    bus.dirL = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    bus.dirL = 1'b1;
    for (int k = 4; k <= 10; k++) begin
      tick();
      check($sformatf("retoggle k%0d busyL", k), int'(bus.busyL), (k <= 9) ? 1 : 0);
    end
    for (int i = 0; i < 30; i++) tick();
    window("retoggle", 6, 0, 6, 0);

    // Drop en during DEAD: abort to STOP, then restart from 0 in the new direction.
    bus.dirL = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    bus.en = 1'b0;
    tick();
    check("en drop k8 busyL", int'(bus.busyL), 1);
    tick();
    check("en drop k9 outputs", int'(outs()), 0);
    bus.en = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    window("restart", 0, 6, 6, 0);

    // Asynchronous reset in the middle of BRAKE.
    bus.dirL = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    check("pre-reset brake", int'({bus.mL_a, bus.mL_b, bus.busyL}), 7);
    #3;
    rst = 1'b0;
    bus.en = 1'b0;
    #1;
    check("async reset outputs", int'(outs()), 0);
    #10;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("stop after reset", int'(outs()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
